// File: rtl/snek_pkg.sv
// Shared encodings and grid defaults for the snake head controller and its helpers.
package snek_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DEAD   = 2'd3
  } state_t;

  localparam int GRID_W_DEF  = 32;
  localparam int GRID_H_DEF  = 24;
  localparam int START_X_DEF = 16;
  localparam int START_Y_DEF = 12;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:   return DIR_DOWN;
      DIR_DOWN: return DIR_UP;
      DIR_LEFT: return DIR_RIGHT;
      default:  return DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snek_tick_sync.sv
// Brings the divided game clock into clk and turns each rising edge into a
// single-cycle tick_req.
module snek_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic tick_req
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick_req = s2 & ~s3;

endmodule

// File: rtl/snek_head_ctrl.sv
// Snake head movement: direction latch, one-cell step per game tick.
// SNEK_WRAP_EN: defined -> head wraps at grid edges; undefined -> leaving the grid kills.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for first button, ticks ignored
// ST_RUN    | moving one cell per tick, buttons load pending
// ST_PAUSED | frozen while pause is high
// ST_DEAD   | wall hit, frozen until rst (no-wrap build)
module snek_head_ctrl
  import snek_pkg::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int X_W     = 5,
  parameter int Y_W     = 5,
  parameter int START_X = START_X_DEF,
  parameter int START_Y = START_Y_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick_in,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           pause,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [1:0]     dir,
  output logic           step,
  output logic           dead
);

  localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);

  logic           tick_req;
  state_t         state;
  dir_t           dir_q, pending_dir, btn_dir;
  logic           btn_any, off_grid;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;

  snek_tick_sync u_tick_sync (
    .clk     (clk),
    .rst     (rst),
    .tick_in (tick_in),
    .tick_req(tick_req)
  );

  always_comb begin
    btn_any = btn_up | btn_down | btn_left | btn_right;
    btn_dir = DIR_RIGHT;
    if (btn_up)        btn_dir = DIR_UP;
    else if (btn_down) btn_dir = DIR_DOWN;
    else if (btn_left) btn_dir = DIR_LEFT;
  end

  // Wrapped next position plus an off-grid flag; the build decides which is used.
  always_comb begin
    nx       = head_x;
    ny       = head_y;
    off_grid = 1'b0;
    case (pending_dir)
      DIR_UP: begin
        if (head_y == '0) begin ny = Y_MAX; off_grid = 1'b1; end
        else ny = head_y - 1'b1;
      end
      DIR_DOWN: begin
        if (head_y == Y_MAX) begin ny = '0; off_grid = 1'b1; end
        else ny = head_y + 1'b1;
      end
      DIR_LEFT: begin
        if (head_x == '0) begin nx = X_MAX; off_grid = 1'b1; end
        else nx = head_x - 1'b1;
      end
      default: begin
        if (head_x == X_MAX) begin nx = '0; off_grid = 1'b1; end
        else nx = head_x + 1'b1;
      end
    endcase
  end

`ifdef SNEK_WRAP_EN
  logic unused_off_grid;
  assign unused_off_grid = off_grid;
  assign dead = 1'b0;
`else
  logic dead_q;
  assign dead = dead_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      head_x      <= X_W'(START_X);
      head_y      <= Y_W'(START_Y);
      dir_q       <= DIR_RIGHT;
      pending_dir <= DIR_RIGHT;
      state       <= ST_IDLE;
      step        <= 1'b0;
`ifndef SNEK_WRAP_EN
      dead_q      <= 1'b0;
`endif
    end else begin
      step <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (btn_any) begin
            pending_dir <= btn_dir;
            dir_q       <= btn_dir;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (btn_any && (btn_dir != opposite(dir_q))) pending_dir <= btn_dir;
          if (pause) state <= ST_PAUSED;
          // Placed after the pause check so a fatal move overrides the pause.
          if (tick_req) begin
`ifndef SNEK_WRAP_EN
            if (off_grid) begin
              state  <= ST_DEAD;
              dead_q <= 1'b1;
            end else
`endif
            begin
              dir_q  <= pending_dir;
              head_x <= nx;
              head_y <= ny;
              step   <= 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) state <= ST_RUN;
        end
`ifndef SNEK_WRAP_EN
        ST_DEAD: ;
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dir = dir_q;

endmodule

// File: tb/tb_snek_head_ctrl.sv
// Directed bench for snek_head_ctrl; expected values are hand-computed constants.
module tb_snek_head_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       pause = 1'b0;
  logic [4:0] head_x, head_y;
  logic [1:0] dir;
  logic       step, dead;

  int total = 0;
  int bad   = 0;

  snek_head_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (tick_in),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .pause    (pause),
    .head_x   (head_x),
    .head_y   (head_y),
    .dir      (dir),
    .step     (step),
    .dead     (dead)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // b: 0 up, 1 down, 2 left, 3 right; held for one clock
  task automatic press(input int b);
    @(negedge clk);
    btn_up    = (b == 0);
    btn_down  = (b == 1);
    btn_left  = (b == 2);
    btn_right = (b == 3);
    @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
  endtask

  // One tick_in pulse over 8 clocks; counts step cycles and the first edge index seeing step.
  task automatic tick(output int n_step, output int first_at);
    n_step   = 0;
    first_at = 0;
    @(negedge clk);
    tick_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (step) begin
        n_step++;
        if (first_at == 0) first_at = i;
      end
      if (i == 4) tick_in = 1'b0;
    end
  endtask

  task automatic ticks(input int n, output int sum);
    int s, f;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      tick(s, f);
      sum += s;
    end
  endtask

  initial begin
    int n, f, sum;

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("rst_x", head_x, 16);
    check("rst_y", head_y, 12);
    check("rst_dir", dir, 3);
    check("rst_step", step, 0);
    check("rst_dead", dead, 0);

    ticks(3, sum);
    check("idle_steps", sum, 0);
    check("idle_x", head_x, 16);
    check("idle_y", head_y, 12);

    press(3);
    check("start_dir", dir, 3);
    for (int k = 1; k <= 3; k++) begin
      tick(n, f);
      check("run_nstep", n, 1);
      check("run_step_edge", f, 3);
      check("run_x", head_x, 16 + k);
    end

    press(2);
    tick(n, f);
    check("rev_x", head_x, 20);
    check("rev_dir", dir, 3);

    press(0);
    press(2);
    tick(n, f);
    check("up_dir", dir, 0);
    check("up_y", head_y, 11);
    check("up_x", head_x, 20);

    @(negedge clk) pause = 1'b1;
    ticks(4, sum);
    check("pause_steps", sum, 0);
    check("pause_x", head_x, 20);
    check("pause_y", head_y, 11);
    @(negedge clk) pause = 1'b0;
    @(negedge clk);
    tick(n, f);
    check("resume_nstep", n, 1);
    check("resume_y", head_y, 10);

    // down outranks right; down is a reversal of UP so nothing changes
    @(negedge clk);
    btn_down = 1'b1; btn_right = 1'b1;
    @(negedge clk);
    btn_down = 1'b0; btn_right = 1'b0;
    tick(n, f);
    check("prio_x", head_x, 20);
    check("prio_y", head_y, 9);
    check("prio_dir", dir, 0);

    press(3);
    ticks(11, sum);
    check("walk_steps", sum, 11);
    check("walk_x", head_x, 31);
    press(0);
    ticks(4, sum);
    check("edge_x", head_x, 31);
    check("edge_y", head_y, 5);

    press(3);
    tick(n, f);
`ifdef SNEK_WRAP_EN
    check("wrap_nstep", n, 1);
    check("wrap_x", head_x, 0);
    check("wrap_dead", dead, 0);
`else
    check("wall_nstep", n, 0);
    check("wall_x", head_x, 31);
    check("wall_y", head_y, 5);
    check("wall_dead", dead, 1);
    tick(n, f);
    check("dead_nstep", n, 0);
    check("dead_x", head_x, 31);
    check("dead_hold", dead, 1);
`endif

    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("rst2_dead", dead, 0);
    press(3);
    tick(n, f);
    check("rst2_x", head_x, 17);

    // rst lands on the same edge that would take the move
    @(negedge clk) tick_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick_in = 1'b0;
    @(posedge clk);
    #1;
    check("coinc_x", head_x, 16);
    check("coinc_y", head_y, 12);
    check("coinc_dir", dir, 3);
    check("coinc_step", step, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    tick(n, f);
    check("coinc_idle_nstep", n, 0);
    check("coinc_idle_x", head_x, 16);

    @(negedge clk);
    btn_down = 1'b1; btn_right = 1'b1;
    @(negedge clk);
    btn_down = 1'b0; btn_right = 1'b0;
    check("idle_prio_dir", dir, 1);
    tick(n, f);
    check("idle_prio_y", head_y, 13);
    check("idle_prio_nstep", n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
